// File: rtl/multicycle_control_if.sv
// Interface between the multicycle control unit and the datapath.
//   opcode, mem_ready         : from datapath / memory into the controller
//   PCWrite .. ALUSrcA        : 1-bit datapath enables and mux selects
//   ALUSrcB, PCSource, ALUOp  : 2-bit mux selects and ALU operation class
//   illegal_op                : pulse while an unsupported opcode is handled
//   estado                    : current controller state for debug
// master = control unit side, slave = datapath side.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic       illegal_op;
    logic [3:0] estado;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource,
               ALUOp, illegal_op, estado
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource,
               ALUOp, illegal_op, estado
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control unit for the multicycle MIPS-subset datapath.
// Moore FSM sequencing fetch / decode / execute / memory / write-back.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; returns the FSM to FETCH
//   bus   : multicycle_control_if.master (opcode, mem_ready in; controls out)
//
// state    | meaning
// ---------+----------------------------------------------
// FETCH  0 | read instruction, PC+4; waits on mem_ready
// DECODE 1 | register read, branch target into ALUOut
// MEMADR 2 | effective address base + imm
// MEMRD  3 | data read; waits on mem_ready
// MEMWB  4 | load data to rt
// MEMWR  5 | data write; waits on mem_ready
// EXEC   6 | R-type ALU op
// RWB    7 | R-type result to rd
// BRANCH 8 | compare, conditional PC update
// JUMP   9 | PC <= jump target
// ILLEG 10 | unsupported opcode, pulse illegal_op
// ADDIEX11 | rs + imm
// ADDIWB12 | result to rt
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic                        clock,
    input  logic                        reset,
    multicycle_control_if.master        bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ILLEGAL = 4'd10,
        S_ADDIEX  = 4'd11,
        S_ADDIWB  = 4'd12
    } state_t;

    state_t state;
    state_t next_state;

    always_ff @(posedge clock) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    assign bus.estado = state;

    always_comb begin
        next_state      = S_FETCH;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.PCSource    = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.illegal_op  = 1'b0;

        case (state)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                // IR and PC only capture once the instruction word has arrived
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
                next_state  = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDIEX;
                    default:      next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                next_state  = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                next_state  = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                next_state   = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
                next_state  = S_RWB;
            end
            S_RWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            S_ILLEGAL: begin
                bus.illegal_op = 1'b1;
            end
            S_ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                next_state  = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.RegWrite = 1'b1;
            end
            // Unreachable encodings: all outputs stay 0, recover to FETCH.
            default: next_state = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle pushes the
// hand-derived expected output word; a negedge monitor pops and compares.
module tb_multicycle_control;

    logic clock;
    logic reset;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word layout:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,RegDst,ALUSrcA,
    //  ALUSrcB[1:0], PCSource[1:0], ALUOp[1:0], illegal_op, estado[3:0]}
    localparam logic [20:0] X_FETCH_NR = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0, 4'd0};
    localparam logic [20:0] X_FETCH_RD = {10'b1001001000, 2'b01, 2'b00, 2'b00, 1'b0, 4'd0};
    localparam logic [20:0] X_DECODE   = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0, 4'd1};
    localparam logic [20:0] X_MEMADR   = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, 4'd2};
    localparam logic [20:0] X_MEMRD    = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0, 4'd3};
    localparam logic [20:0] X_MEMWB    = {10'b0000010100, 2'b00, 2'b00, 2'b00, 1'b0, 4'd4};
    localparam logic [20:0] X_MEMWR    = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0, 4'd5};
    localparam logic [20:0] X_EXEC     = {10'b0000000001, 2'b00, 2'b00, 2'b10, 1'b0, 4'd6};
    localparam logic [20:0] X_RWB      = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0, 4'd7};
    localparam logic [20:0] X_BRANCH   = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0, 4'd8};
    localparam logic [20:0] X_JUMP     = {10'b1000000000, 2'b00, 2'b10, 2'b00, 1'b0, 4'd9};
    localparam logic [20:0] X_ILLEG    = {10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b1, 4'd10};
    localparam logic [20:0] X_ADDIEX   = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, 4'd11};
    localparam logic [20:0] X_ADDIWB   = {10'b0000000100, 2'b00, 2'b00, 2'b00, 1'b0, 4'd12};

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;

    logic [20:0] exp_q[$];
    string       name_q[$];
    int          checks   = 0;
    int          failures = 0;

    logic [20:0] act;
    assign act = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.MemtoReg, bus.IRWrite, bus.RegWrite, bus.RegDst, bus.ALUSrcA,
                  bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.illegal_op, bus.estado};

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [20:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s: got %b (estado %0d) expected %b (estado %0d)",
                         n, act, act[3:0], e, e[3:0]);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during it.
    task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                        input logic [20:0] e, input string n);
        reset         = r;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b0;
        @(posedge clock);
        #1;

        // reset held, then idle with mem_ready low
        step(1, RT, 0, X_FETCH_NR, "reset_cyc1");
        step(1, RT, 0, X_FETCH_NR, "reset_cyc2");
        step(0, RT, 0, X_FETCH_NR, "idle_1");
        step(0, RT, 0, X_FETCH_NR, "idle_2");
        step(0, RT, 0, X_FETCH_NR, "idle_3");

        // LW; opcode flipped in MEMRD must not matter
        step(0, LW, 1, X_FETCH_RD, "lw_fetch");
        step(0, LW, 1, X_DECODE,   "lw_decode");
        step(0, LW, 1, X_MEMADR,   "lw_memadr");
        step(0, SW, 1, X_MEMRD,    "lw_memrd");
        step(0, SW, 1, X_MEMWB,    "lw_memwb");

        // R-type with mem_ready low outside memory states
        step(0, RT, 1, X_FETCH_RD, "rt_fetch");
        step(0, RT, 0, X_DECODE,   "rt_decode");
        step(0, RT, 0, X_EXEC,     "rt_exec");
        step(0, RT, 0, X_RWB,      "rt_rwb");

        // BEQ
        step(0, BEQ, 1, X_FETCH_RD, "beq_fetch");
        step(0, BEQ, 1, X_DECODE,   "beq_decode");
        step(0, BEQ, 1, X_BRANCH,   "beq_branch");

        // SW with two stall cycles in MEMWR
        step(0, SW, 1, X_FETCH_RD, "sw_fetch");
        step(0, SW, 1, X_DECODE,   "sw_decode");
        step(0, SW, 1, X_MEMADR,   "sw_memadr");
        step(0, SW, 0, X_MEMWR,    "sw_stall_1");
        step(0, SW, 0, X_MEMWR,    "sw_stall_2");
        step(0, SW, 1, X_MEMWR,    "sw_done");

        // Illegal opcode
        step(0, BAD, 1, X_FETCH_RD, "ill_fetch");
        step(0, BAD, 1, X_DECODE,   "ill_decode");
        step(0, BAD, 1, X_ILLEG,    "ill_state");

        // Jump, preceded by one fetch stall
        step(0, JMP, 0, X_FETCH_NR, "j_fetch_stall");
        step(0, JMP, 1, X_FETCH_RD, "j_fetch");
        step(0, JMP, 1, X_DECODE,   "j_decode");
        step(0, JMP, 1, X_JUMP,     "j_jump");

        // ADDI
        step(0, ADDI, 1, X_FETCH_RD, "addi_fetch");
        step(0, ADDI, 1, X_DECODE,   "addi_decode");
        step(0, ADDI, 1, X_ADDIEX,   "addi_ex");
        step(0, ADDI, 1, X_ADDIWB,   "addi_wb");

        // Reset during a stalled load
        step(0, LW, 1, X_FETCH_RD, "rst_lw_fetch");
        step(0, LW, 1, X_DECODE,   "rst_lw_decode");
        step(0, LW, 1, X_MEMADR,   "rst_lw_memadr");
        step(0, LW, 0, X_MEMRD,    "rst_lw_stall");
        step(1, LW, 0, X_MEMRD,    "rst_lw_rst_cycle");
        step(0, LW, 0, X_FETCH_NR, "rst_lw_after");
        step(0, LW, 1, X_FETCH_RD, "rst_lw_refetch");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle MIPS-subset datapath. A Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, and produces the 2-bit `ALUOp` that `ALUControl` combines with `funct` to select the ALU operation. Memory-access states stall on a `mem_ready` handshake.

## Interface
Parameters:
- `OP_RTYPE`, 6'b000000, R-type opcode
- `OP_LW`, 6'b100011, load word
- `OP_SW`, 6'b101011, store word
- `OP_BEQ`, 6'b000100, branch if equal
- `OP_J`, 6'b000010, jump
- `OP_ADDI`, 6'b001000, add immediate

Ports:
- `clock` in 1: single clock; all state changes on its rising edge
- `reset` in 1: synchronous, active-high; forces state FETCH at the next rising edge
- `opcode` in 6: instruction register bits [31:26]; valid from DECODE onward
- `mem_ready` in 1: memory completes the current access this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA` out 1: datapath controls
- `ALUSrcB` out 2: ALU B select (00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2)
- `PCSource` out 2: PC select (00 ALU result, 01 ALUOut, 10 jump target)
- `ALUOp` out 2: to ALUControl (00 add, 01 subtract, 10 decode `funct`)
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode
- `estado` out 4: current state, for debug and verification

## Operation
State encoding (4 bits) and asserted outputs. Any output not listed is 0.
- 0 FETCH: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite equal `mem_ready`, the only Mealy-gated outputs. Moves to DECODE when `mem_ready`=1, otherwise holds.
- 1 DECODE: ALUSrcB=11, ALUOp=00 (branch target computed into ALUOut). Next state by opcode:
  - LW or SW → 2
  - RTYPE → 6
  - BEQ → 8
  - J → 9
  - ADDI → 11
  - any other value → 10
- 2 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Moves to 3 if opcode=LW, otherwise to 5.
- 3 MEMRD: MemRead=1, IorD=1. Moves to 4 when `mem_ready`=1, otherwise holds.
- 4 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Moves to 0.
- 5 MEMWR: MemWrite=1, IorD=1. Moves to 0 when `mem_ready`=1, otherwise holds.
- 6 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Moves to 7.
- 7 RWB: RegDst=1, MemtoReg=0, RegWrite=1. Moves to 0.
- 8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Moves to 0.
- 9 JUMP: PCWrite=1, PCSource=10. Moves to 0.
- 10 ILLEGAL: illegal_op=1. Moves to 0.
- 11 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Moves to 12.
- 12 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Moves to 0.
- Encodings 13–15 are unreachable. If entered, all outputs are 0 and the next state is 0.

## Timing
- Reset: at the rising edge where `reset`=1, the state becomes 0 regardless of current state or `mem_ready`. Reset takes priority over every transition.
- Output values after reset (state 0): MemRead=1, ALUSrcB=01, `estado`=0, IRWrite=PCWrite=`mem_ready`, all others 0.
- Every output except IRWrite and PCWrite is a pure function of the registered state, so all are glitch-free relative to `opcode` changes.
- Cycles per instruction with `mem_ready` held at 1:
  - LW: 5
  - SW, R-type, ADDI: 4
  - BEQ, J, illegal: 3
- Each cycle with `mem_ready`=0 in states 0, 3 or 5 adds exactly one cycle. No timeout.
- `opcode` is sampled only in states 1 and 2. Changes in other states have no effect.
- `mem_ready` is ignored in every state other than 0, 3 and 5.
- A reset asserted mid-stall (e.g. in state 3 with `mem_ready`=0) returns the state to 0 at the next edge. No write strobe is asserted in that cycle.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles, `mem_ready`=0.
  - Required: `estado`=0, MemRead=1, ALUSrcB=01, PCWrite=IRWrite=0 for 3 cycles with no state change.
- LW, `opcode`=100011, `mem_ready`=1.
  - Required: `estado` sequence 0,1,2,3,4,0.
  - In state 3: IorD=1, MemRead=1.
  - In state 4: RegWrite=1, MemtoReg=1.
- R-type then BEQ, `mem_ready`=1.
  - R-type: sequence 0,1,6,7,0, with ALUOp=10 in state 6 and RegDst=1 in state 7.
  - BEQ (`opcode`=000100): sequence 0,1,8,0, with ALUOp=01, PCWriteCond=1 and PCSource=01 in state 8.
- SW with stall: `opcode`=101011, `mem_ready` low for 2 cycles on entering state 5.
  - Required: state 5 held for 3 cycles with MemWrite=1 throughout, then state 0.
- Illegal opcode: `opcode`=111111.
  - Required: sequence 0,1,10,0.
  - `illegal_op`=1 only in state 10.
  - RegWrite, MemWrite, PCWrite and PCWriteCond all 0 in states 1 and 10.
- Reset mid-instruction: assert `reset` while in state 3 with `mem_ready`=0.
  - Required: `estado`=0 after the next edge.
  - Required: MemRead=1, IorD=0, RegWrite=0.
